// File: rtl/decode_if.sv
// Decode stage bus: instruction in, decoded fields out.
// The master drives the instruction; the slave (decode) drives the fields.
interface decode_if #(
    parameter int AWIDTH    = 5,
    parameter int IWIDTH    = 32,
    parameter int IMM_WIDTH = 16
);
    localparam int OPCODE_WIDTH = 6;
    localparam int FUNCT_WIDTH  = 6;

    logic                    d_i_ce;
    logic [IWIDTH-1:0]       d_i_instr;
    logic [OPCODE_WIDTH-1:0] d_o_opcode;
    logic [FUNCT_WIDTH-1:0]  d_o_funct;
    logic [AWIDTH-1:0]       d_o_addr_rs;
    logic [AWIDTH-1:0]       d_o_addr_rt;
    logic [AWIDTH-1:0]       d_o_addr_rd;
    logic [AWIDTH-1:0]       d_o_shamt;
    logic [IMM_WIDTH-1:0]    d_o_imm;
    logic [25:0]             d_o_jaddr;
    logic                    d_o_rtype;
    logic                    d_o_itype;
    logic                    d_o_jtype;
    logic [AWIDTH-1:0]       d_o_addr_wr;
    logic                    d_o_wr_reg;
    logic                    d_o_ce;

    modport master (
        output d_i_ce, d_i_instr,
        input  d_o_opcode, d_o_funct, d_o_addr_rs, d_o_addr_rt,
        input  d_o_addr_rd, d_o_shamt, d_o_imm, d_o_jaddr,
        input  d_o_rtype, d_o_itype, d_o_jtype,
        input  d_o_addr_wr, d_o_wr_reg, d_o_ce
    );

    modport slave (
        input  d_i_ce, d_i_instr,
        output d_o_opcode, d_o_funct, d_o_addr_rs, d_o_addr_rt,
        output d_o_addr_rd, d_o_shamt, d_o_imm, d_o_jaddr,
        output d_o_rtype, d_o_itype, d_o_jtype,
        output d_o_addr_wr, d_o_wr_reg, d_o_ce
    );
endinterface

// File: rtl/decode.sv
// MIPS instruction-decode stage: field split, R/I/J classification and
// destination register selection, all registered with one cycle latency.
module decode #(
    parameter int AWIDTH    = 5,
    parameter int DWIDTH    = 32,
    parameter int IWIDTH    = 32,
    parameter int IMM_WIDTH = 16
) (
    input logic      d_clk,
    input logic      d_rst,
    decode_if.slave  bus
);
    localparam int OPCODE_WIDTH = 6;
    localparam int FUNCT_WIDTH  = 6;

    localparam logic [OPCODE_WIDTH-1:0] OP_RTYPE = 6'h00;
    localparam logic [OPCODE_WIDTH-1:0] OP_J     = 6'h02;
    localparam logic [OPCODE_WIDTH-1:0] OP_JAL   = 6'h03;
    localparam logic [FUNCT_WIDTH-1:0]  FN_JR    = 6'h08;
    localparam logic [AWIDTH-1:0]       REG_RA   = AWIDTH'(31);

    // The field slicing below assumes the fixed 32-bit MIPS encoding and a
    // datapath at least as wide as an instruction.
    if (IWIDTH != 32 || DWIDTH < IWIDTH) begin : g_bad_width
        $error("decode: unsupported IWIDTH/DWIDTH");
    end

    logic [OPCODE_WIDTH-1:0] opcode;
    logic [FUNCT_WIDTH-1:0]  funct_raw;
    logic [AWIDTH-1:0]       rs;
    logic [AWIDTH-1:0]       rt;
    logic [AWIDTH-1:0]       rd_raw;
    logic [AWIDTH-1:0]       shamt_raw;
    logic [IMM_WIDTH-1:0]    imm_raw;
    logic [25:0]             jaddr_raw;

    assign opcode    = bus.d_i_instr[31:26];
    assign rs        = bus.d_i_instr[25:21];
    assign rt        = bus.d_i_instr[20:16];
    assign rd_raw    = bus.d_i_instr[15:11];
    assign shamt_raw = bus.d_i_instr[10:6];
    assign funct_raw = bus.d_i_instr[5:0];
    assign imm_raw   = bus.d_i_instr[15:0];
    assign jaddr_raw = bus.d_i_instr[25:0];

    logic                   is_r;
    logic                   is_j;
    logic                   is_i;
    logic                   is_alu_imm;
    logic                   is_load;
    logic [FUNCT_WIDTH-1:0] funct;
    logic [AWIDTH-1:0]      rd;
    logic [AWIDTH-1:0]      shamt;
    logic [IMM_WIDTH-1:0]   imm;
    logic [25:0]            jaddr;
    logic [AWIDTH-1:0]      dest;
    logic                   wr;

    // Classify the opcode and mask off fields that do not belong to its type.
    always_comb begin
        is_r       = (opcode == OP_RTYPE);
        is_j       = (opcode == OP_J) || (opcode == OP_JAL);
        is_i       = !is_r && !is_j;
        is_alu_imm = (opcode[5:3] == 3'b001);
        is_load    = (opcode[5:3] == 3'b100) && (opcode[2:0] <= 3'd5);
        funct      = is_r ? funct_raw : '0;
        rd         = is_r ? rd_raw : '0;
        shamt      = is_r ? shamt_raw : '0;
        imm        = is_i ? imm_raw : '0;
        jaddr      = is_j ? jaddr_raw : '0;
    end

    // Pick the write-back register; writes to $0 are never enabled.
    always_comb begin
        dest = '0;
        wr   = 1'b0;
        unique case (1'b1)
            is_r: begin
                dest = rd_raw;
                wr   = (funct_raw != FN_JR);
            end
            is_alu_imm, is_load: begin
                dest = rt;
                wr   = 1'b1;
            end
            (opcode == OP_JAL): begin
                dest = REG_RA;
                wr   = 1'b1;
            end
            default: begin
                dest = '0;
                wr   = 1'b0;
            end
        endcase
        if (dest == '0) begin
            wr = 1'b0;
        end
    end

    // Output registers: load on enable, hold otherwise, clear on reset.
    always_ff @(posedge d_clk or posedge d_rst) begin
        if (d_rst) begin
            bus.d_o_opcode  <= '0;
            bus.d_o_funct   <= '0;
            bus.d_o_addr_rs <= '0;
            bus.d_o_addr_rt <= '0;
            bus.d_o_addr_rd <= '0;
            bus.d_o_shamt   <= '0;
            bus.d_o_imm     <= '0;
            bus.d_o_jaddr   <= '0;
            bus.d_o_rtype   <= 1'b0;
            bus.d_o_itype   <= 1'b0;
            bus.d_o_jtype   <= 1'b0;
            bus.d_o_addr_wr <= '0;
            bus.d_o_wr_reg  <= 1'b0;
            bus.d_o_ce      <= 1'b0;
        end else begin
            bus.d_o_ce <= bus.d_i_ce;
            if (bus.d_i_ce) begin
                bus.d_o_opcode  <= opcode;
                bus.d_o_funct   <= funct;
                bus.d_o_addr_rs <= rs;
                bus.d_o_addr_rt <= rt;
                bus.d_o_addr_rd <= rd;
                bus.d_o_shamt   <= shamt;
                bus.d_o_imm     <= imm;
                bus.d_o_jaddr   <= jaddr;
                bus.d_o_rtype   <= is_r;
                bus.d_o_itype   <= is_i;
                bus.d_o_jtype   <= is_j;
                bus.d_o_addr_wr <= dest;
                bus.d_o_wr_reg  <= wr;
            end
        end
    end
endmodule

// File: tb/tb_decode.sv
// Directed testbench for the decode stage.
// Inputs change on the falling edge; outputs are sampled 1ns after rising.
module tb_decode;
    logic clk;
    logic rst;
    int   checks;
    int   fails;

    decode_if #(.AWIDTH(5), .IWIDTH(32), .IMM_WIDTH(16)) bus ();

    decode #(
        .AWIDTH(5), .DWIDTH(32), .IWIDTH(32), .IMM_WIDTH(16)
    ) dut (
        .d_clk (clk),
        .d_rst (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [83:0] outs;
    always_comb begin
        outs = {bus.d_o_opcode, bus.d_o_funct, bus.d_o_addr_rs,
                bus.d_o_addr_rt, bus.d_o_addr_rd, bus.d_o_shamt,
                bus.d_o_imm, bus.d_o_jaddr, bus.d_o_rtype,
                bus.d_o_itype, bus.d_o_jtype, bus.d_o_addr_wr,
                bus.d_o_wr_reg, bus.d_o_ce};
    end

    // Apply one instruction at the falling edge, return after the rising edge.
    task automatic issue(input logic ce, input logic [31:0] instr);
        @(negedge clk);
        bus.d_i_ce    = ce;
        bus.d_i_instr = instr;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.d_i_ce = 1'b1;
        bus.d_i_instr = 32'h00430820;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (outs !== '0) begin
            fails++;
            $display("FAIL reset_hold got %h want 0", outs);
        end
        @(negedge clk);
        rst = 1'b0;
        bus.d_i_ce = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (outs !== '0) begin
            fails++;
            $display("FAIL reset_release got %h want 0", outs);
        end
    endtask

    task automatic test_rtype();
        issue(1'b1, 32'h00430820);
        checks++;
        if ({bus.d_o_opcode, bus.d_o_addr_rs, bus.d_o_addr_rt,
             bus.d_o_addr_rd, bus.d_o_shamt, bus.d_o_funct}
            !== {6'd0, 5'd2, 5'd3, 5'd1, 5'd0, 6'h20}) begin
            fails++;
            $display("FAIL add_fields got op%h rs%0d rt%0d rd%0d fn%h",
                     bus.d_o_opcode, bus.d_o_addr_rs, bus.d_o_addr_rt,
                     bus.d_o_addr_rd, bus.d_o_funct);
        end
        checks++;
        if ({bus.d_o_rtype, bus.d_o_itype, bus.d_o_jtype,
             bus.d_o_addr_wr, bus.d_o_wr_reg, bus.d_o_imm,
             bus.d_o_jaddr, bus.d_o_ce}
            !== {3'b100, 5'd1, 1'b1, 16'h0, 26'h0, 1'b1}) begin
            fails++;
            $display("FAIL add_ctrl got r%b i%b j%b wr%0d we%b imm%h ce%b",
                     bus.d_o_rtype, bus.d_o_itype, bus.d_o_jtype,
                     bus.d_o_addr_wr, bus.d_o_wr_reg, bus.d_o_imm,
                     bus.d_o_ce);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] instrs [4];
        logic [20:0] exp    [4];
        instrs = '{32'h00A62021, 32'h01093822, 32'h016C5023, 32'h01CF6824};
        exp    = '{{5'd5, 5'd6, 5'd4, 6'h21}, {5'd8, 5'd9, 5'd7, 6'h22},
                   {5'd11, 5'd12, 5'd10, 6'h23},
                   {5'd14, 5'd15, 5'd13, 6'h24}};
        for (int i = 0; i < 4; i++) begin
            issue(1'b1, instrs[i]);
            checks++;
            if ({bus.d_o_addr_rs, bus.d_o_addr_rt, bus.d_o_addr_rd,
                 bus.d_o_funct} !== exp[i]
                || bus.d_o_ce !== 1'b1 || bus.d_o_wr_reg !== 1'b1
                || bus.d_o_addr_wr !== exp[i][10:6]) begin
                fails++;
                $display("FAIL b2b_%0d got rs%0d rt%0d rd%0d fn%h ce%b we%b",
                         i, bus.d_o_addr_rs, bus.d_o_addr_rt,
                         bus.d_o_addr_rd, bus.d_o_funct, bus.d_o_ce,
                         bus.d_o_wr_reg);
            end
        end
    endtask

    task automatic test_itype_jtype();
        logic [31:0] instrs [7];
        logic [51:0] exp    [7];
        string       names  [7];
        // {r,i,j, rs, rt, rd, funct, imm, addr_wr, wr}
        instrs = '{32'h8C430004, 32'h0C000010, 32'h10430005,
                   32'h20410005, 32'hAC430004, 32'h94430004,
                   32'h20000001};
        names  = '{"lw", "jal", "beq", "addi", "sw", "lhu", "addi_r0"};
        exp    = '{{3'b010, 5'd2, 5'd3, 5'd0, 6'd0, 16'h0004, 5'd3, 1'b1},
                   {3'b001, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0000, 5'd31, 1'b1},
                   {3'b010, 5'd2, 5'd3, 5'd0, 6'd0, 16'h0005, 5'd0, 1'b0},
                   {3'b010, 5'd2, 5'd1, 5'd0, 6'd0, 16'h0005, 5'd1, 1'b1},
                   {3'b010, 5'd2, 5'd3, 5'd0, 6'd0, 16'h0004, 5'd0, 1'b0},
                   {3'b010, 5'd2, 5'd3, 5'd0, 6'd0, 16'h0004, 5'd3, 1'b1},
                   {3'b010, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0001, 5'd0, 1'b0}};
        for (int i = 0; i < 7; i++) begin
            issue(1'b1, instrs[i]);
            checks++;
            if ({bus.d_o_rtype, bus.d_o_itype, bus.d_o_jtype,
                 bus.d_o_addr_rs, bus.d_o_addr_rt, bus.d_o_addr_rd,
                 bus.d_o_funct, bus.d_o_imm, bus.d_o_addr_wr,
                 bus.d_o_wr_reg} !== exp[i]) begin
                fails++;
                $display("FAIL %s got %h want %h", names[i],
                         {bus.d_o_rtype, bus.d_o_itype, bus.d_o_jtype,
                          bus.d_o_addr_rs, bus.d_o_addr_rt,
                          bus.d_o_addr_rd, bus.d_o_funct, bus.d_o_imm,
                          bus.d_o_addr_wr, bus.d_o_wr_reg}, exp[i]);
            end
            checks++;
            if (bus.d_o_jaddr !== (i == 1 ? 26'h10 : 26'h0)
                || bus.d_o_opcode !== instrs[i][31:26]) begin
                fails++;
                $display("FAIL %s_jaddr got %h op %h", names[i],
                         bus.d_o_jaddr, bus.d_o_opcode);
            end
        end
    endtask

    task automatic test_enable_hold();
        issue(1'b1, 32'h01CF6824);
        issue(1'b0, 32'hFFFFFFFF);
        checks++;
        if (bus.d_o_ce !== 1'b0) begin
            fails++;
            $display("FAIL hold_ce got %b want 0", bus.d_o_ce);
        end
        checks++;
        if ({bus.d_o_addr_rd, bus.d_o_addr_rs, bus.d_o_addr_rt,
             bus.d_o_funct, bus.d_o_rtype, bus.d_o_wr_reg}
            !== {5'd13, 5'd14, 5'd15, 6'h24, 1'b1, 1'b1}) begin
            fails++;
            $display("FAIL hold_fields got rd%0d rs%0d rt%0d fn%h",
                     bus.d_o_addr_rd, bus.d_o_addr_rs, bus.d_o_addr_rt,
                     bus.d_o_funct);
        end
    endtask

    task automatic test_async_reset();
        issue(1'b1, 32'h00430820);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (outs !== '0) begin
            fails++;
            $display("FAIL async_clear got %h want 0", outs);
        end
        @(negedge clk);
        rst = 1'b0;
        bus.d_i_ce = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (outs !== '0) begin
            fails++;
            $display("FAIL async_after got %h want 0", outs);
        end
    endtask

    task automatic test_nop_jr();
        issue(1'b1, 32'h00000000);
        checks++;
        if ({bus.d_o_rtype, bus.d_o_itype, bus.d_o_jtype,
             bus.d_o_wr_reg, bus.d_o_addr_wr, bus.d_o_ce}
            !== {3'b100, 1'b0, 5'd0, 1'b1}) begin
            fails++;
            $display("FAIL nop got r%b i%b j%b we%b dst%0d ce%b",
                     bus.d_o_rtype, bus.d_o_itype, bus.d_o_jtype,
                     bus.d_o_wr_reg, bus.d_o_addr_wr, bus.d_o_ce);
        end
        issue(1'b1, 32'h03E00008);
        checks++;
        if ({bus.d_o_rtype, bus.d_o_wr_reg, bus.d_o_addr_rs,
             bus.d_o_funct, bus.d_o_addr_wr}
            !== {1'b1, 1'b0, 5'd31, 6'h08, 5'd0}) begin
            fails++;
            $display("FAIL jr got r%b we%b rs%0d fn%h dst%0d",
                     bus.d_o_rtype, bus.d_o_wr_reg, bus.d_o_addr_rs,
                     bus.d_o_funct, bus.d_o_addr_wr);
        end
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        rst = 1'b1;
        bus.d_i_ce = 1'b0;
        bus.d_i_instr = '0;
        test_reset();
        test_rtype();
        test_back_to_back();
        test_itype_jtype();
        test_enable_hold();
        test_async_reset();
        test_nop_jr();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end
endmodule
